// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - AHB encodings, controller FSM states and alignment helper
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  // Sizes above a word cannot be carried on a 32-bit bus, so they count as misaligned.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = addr_lo[0];
      HSIZE_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_master_ctrl_if.sv
// rtl/ahb_master_ctrl_if.sv - command/response and AHB bus signals of the single-transfer master
interface ahb_master_ctrl_if;

  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [2:0]  cmd_size;

  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_rdata;

  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size,
    output cmd_ready,
    output rsp_valid, rsp_error, rsp_rdata,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    input  HRDATA, HREADY, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_size,
    input  cmd_ready,
    input  rsp_valid, rsp_error, rsp_rdata,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
    output HRDATA, HREADY, HRESP
  );

endinterface

// File: rtl/ahb_lane_align.sv
// rtl/ahb_lane_align.sv - write-data lane replication and read-data lane extraction
module ahb_lane_align
  import ahb_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] hrdata,
  output logic [31:0] hwdata,
  output logic [31:0] rdata
);

  always_comb begin
    hwdata = wdata;
    rdata  = hrdata;
    case (size)
      HSIZE_BYTE: begin
        hwdata = {4{wdata[7:0]}};
        case (addr_lo)
          2'd0:    rdata = {24'h0, hrdata[7:0]};
          2'd1:    rdata = {24'h0, hrdata[15:8]};
          2'd2:    rdata = {24'h0, hrdata[23:16]};
          default: rdata = {24'h0, hrdata[31:24]};
        endcase
      end
      HSIZE_HALF: begin
        hwdata = {2{wdata[15:0]}};
        rdata  = addr_lo[1] ? {16'h0, hrdata[31:16]} : {16'h0, hrdata[15:0]};
      end
      default: begin
        hwdata = wdata;
        rdata  = hrdata;
      end
    endcase
  end

endmodule

// File: rtl/ahb_master_ctrl.sv
// rtl/ahb_master_ctrl.sv - single non-pipelined AHB master driven by a command/response handshake
module ahb_master_ctrl
  import ahb_pkg::*;
#(
  parameter logic [3:0] HPROT_VAL = 4'b0011
) (
  input logic               HCLK,
  input logic               HRESETn,
  ahb_master_ctrl_if.master bus
);

  state_t      state;
  logic        write_r;
  logic [1:0]  addr_lo_r;
  logic [31:0] wdata_r;
  logic [2:0]  size_r;
  logic [31:0] hwdata_rep;
  logic [31:0] rdata_ext;

  assign bus.cmd_ready = (state == IDLE);
  assign bus.HBURST    = HBURST_SINGLE;
  assign bus.HPROT     = HPROT_VAL;

  ahb_lane_align u_lane_align (
    .size    (size_r),
    .addr_lo (addr_lo_r),
    .wdata   (wdata_r),
    .hrdata  (bus.HRDATA),
    .hwdata  (hwdata_rep),
    .rdata   (rdata_ext)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state         <= IDLE;
      write_r       <= 1'b0;
      addr_lo_r     <= 2'b00;
      wdata_r       <= 32'h0;
      size_r        <= HSIZE_BYTE;
      bus.HTRANS    <= HTRANS_IDLE;
      bus.HADDR     <= 32'h0;
      bus.HWRITE    <= 1'b0;
      bus.HSIZE     <= HSIZE_BYTE;
      bus.HWDATA    <= 32'h0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_error <= 1'b0;
      bus.rsp_rdata <= 32'h0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            if (misaligned(bus.cmd_size, bus.cmd_addr[1:0])) begin
              bus.rsp_valid <= 1'b1;
              bus.rsp_error <= 1'b1;
              bus.rsp_rdata <= 32'h0;
            end else begin
              state      <= ADDR;
              write_r    <= bus.cmd_write;
              addr_lo_r  <= bus.cmd_addr[1:0];
              wdata_r    <= bus.cmd_wdata;
              size_r     <= bus.cmd_size;
              bus.HTRANS <= HTRANS_NONSEQ;
              bus.HADDR  <= bus.cmd_addr;
              bus.HWRITE <= bus.cmd_write;
              bus.HSIZE  <= bus.cmd_size;
            end
          end
        end
        ADDR: begin
          if (bus.HREADY) begin
            state      <= DATA;
            bus.HTRANS <= HTRANS_IDLE;
            bus.HWDATA <= hwdata_rep;
          end
        end
        DATA: begin
          // First ERROR cycle has HREADY low, so only the completing edge is acted on.
          if (bus.HREADY) begin
            state         <= IDLE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_error <= bus.HRESP;
            bus.rsp_rdata <= (bus.HRESP || write_r) ? 32'h0 : rdata_ext;
          end
        end
        default: begin
          state      <= IDLE;
          bus.HTRANS <= HTRANS_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// tb/tb_ahb_master_ctrl.sv - directed self-checking bench for ahb_master_ctrl
module tb_ahb_master_ctrl;

  logic HCLK;
  logic HRESETn;
  int   checks;
  int   failures;

  ahb_master_ctrl_if bus ();

  ahb_master_ctrl #(.HPROT_VAL(4'b0011)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus.master)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic drive_cmd(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    bus.cmd_size  = s;
  endtask

  task automatic test_reset;
    HRESETn = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    checks++; if (bus.HTRANS !== 2'b00) begin failures++; $display("FAIL rst_htrans got=%h exp=0", bus.HTRANS); end
    checks++; if (bus.HADDR !== 32'h0) begin failures++; $display("FAIL rst_haddr got=%h exp=0", bus.HADDR); end
    checks++; if (bus.HWRITE !== 1'b0 || bus.HSIZE !== 3'd0) begin failures++; $display("FAIL rst_hwrite_hsize got=%b/%h exp=0/0", bus.HWRITE, bus.HSIZE); end
    checks++; if (bus.HWDATA !== 32'h0) begin failures++; $display("FAIL rst_hwdata got=%h exp=0", bus.HWDATA); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL rst_rsp got=%b/%b/%h exp=0/0/0", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); end
    checks++; if (bus.HBURST !== 3'b000 || bus.HPROT !== 4'b0011) begin failures++; $display("FAIL rst_hburst_hprot got=%h/%h exp=0/3", bus.HBURST, bus.HPROT); end
    HRESETn = 1'b1;
    @(negedge HCLK);
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_cmd_ready got=%b exp=1", bus.cmd_ready); end
  endtask

  task automatic test_word_read;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    drive_cmd(1'b0, 32'h0000_0100, 32'h0, 3'd2);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h100) begin failures++; $display("FAIL wr_addr_phase got=%h/%h exp=2/100", bus.HTRANS, bus.HADDR); end
    checks++; if (bus.HWRITE !== 1'b0 || bus.HSIZE !== 3'd2 || bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL wr_ctrl got=%b/%h/%b exp=0/2/0", bus.HWRITE, bus.HSIZE, bus.cmd_ready); end
    bus.HRDATA = 32'hDEAD_BEEF;
    @(negedge HCLK);
    checks++; if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL wr_data_phase got=%h/%b exp=0/0", bus.HTRANS, bus.rsp_valid); end
    @(negedge HCLK);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_rsp got=%b/%b/%h exp=1/0/deadbeef", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL wr_ready_after got=%b exp=1", bus.cmd_ready); end
    @(negedge HCLK);
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_pulse got=%b/%h exp=0/deadbeef", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_byte_write_wait;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    drive_cmd(1'b1, 32'h0000_0203, 32'h0000_005A, 3'd0);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.HTRANS !== 2'b10 || bus.HSIZE !== 3'd0 || bus.HWRITE !== 1'b1 || bus.HADDR !== 32'h203) begin failures++; $display("FAIL bw_addr_phase got=%h/%h/%b/%h exp=2/0/1/203", bus.HTRANS, bus.HSIZE, bus.HWRITE, bus.HADDR); end
    @(negedge HCLK);
    bus.HREADY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus.HWDATA !== 32'h5A5A_5A5A || bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL bw_data_cycle%0d got=%h/%h/%b exp=5a5a5a5a/0/0", i, bus.HWDATA, bus.HTRANS, bus.rsp_valid); end
      bus.HREADY = (i == 2);
      @(negedge HCLK);
    end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b0 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL bw_rsp got=%b/%b/%h exp=1/0/0", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); end
  endtask

  task automatic test_narrow_read;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'h1234_5678;
    drive_cmd(1'b0, 32'h0000_0302, 32'h0, 3'd1);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0000_1234) begin failures++; $display("FAIL half_rd got=%b/%h exp=1/00001234", bus.rsp_valid, bus.rsp_rdata); end
    drive_cmd(1'b0, 32'h0000_0101, 32'h0, 3'd0);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0000_0056) begin failures++; $display("FAIL byte_rd got=%b/%h exp=1/00000056", bus.rsp_valid, bus.rsp_rdata); end
  endtask

  task automatic test_misaligned;
    drive_cmd(1'b1, 32'h0000_0401, 32'h1111_2222, 3'd2);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.HTRANS !== 2'b00 || bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL mis_word_nobus got=%h/%b exp=0/1", bus.HTRANS, bus.cmd_ready); end
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1) begin failures++; $display("FAIL mis_word_rsp got=%b/%b exp=1/1", bus.rsp_valid, bus.rsp_error); end
    @(negedge HCLK);
    checks++; if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL mis_pulse got=%b exp=0", bus.rsp_valid); end
    drive_cmd(1'b0, 32'h0000_0400, 32'h0, 3'd3);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1) begin failures++; $display("FAIL mis_size3 got=%h/%b/%b exp=0/1/1", bus.HTRANS, bus.rsp_valid, bus.rsp_error); end
    @(negedge HCLK);
  endtask

  task automatic test_error_resp;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'hFFFF_FFFF;
    drive_cmd(1'b0, 32'h0000_0500, 32'h0, 3'd2);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    @(negedge HCLK);
    bus.HRESP = 1'b1; bus.HREADY = 1'b0;
    checks++; if (bus.HTRANS !== 2'b00) begin failures++; $display("FAIL err_htrans1 got=%h exp=0", bus.HTRANS); end
    @(negedge HCLK);
    checks++; if (bus.HTRANS !== 2'b00 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL err_hold got=%h/%b/%b exp=0/0/0", bus.HTRANS, bus.rsp_valid, bus.cmd_ready); end
    bus.HREADY = 1'b1;
    @(negedge HCLK);
    bus.HRESP = 1'b0;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_error !== 1'b1 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL err_rsp got=%b/%b/%h exp=1/1/0", bus.rsp_valid, bus.rsp_error, bus.rsp_rdata); end
    @(negedge HCLK);
  endtask

  task automatic test_back_to_back;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'hCAFE_F00D;
    drive_cmd(1'b0, 32'h0000_0600, 32'h0, 3'd2);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    @(negedge HCLK);
    @(negedge HCLK);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b1 || bus.rsp_rdata !== 32'hCAFE_F00D) begin failures++; $display("FAIL b2b_rsp got=%b/%b/%h exp=1/1/cafef00d", bus.rsp_valid, bus.cmd_ready, bus.rsp_rdata); end
    drive_cmd(1'b1, 32'h0000_0604, 32'h1122_3344, 3'd2);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h604 || bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL b2b_accept got=%h/%h/%b exp=2/604/0", bus.HTRANS, bus.HADDR, bus.rsp_valid); end
    checks++; if (bus.rsp_rdata !== 32'hCAFE_F00D || bus.rsp_error !== 1'b0) begin failures++; $display("FAIL b2b_hold got=%h/%b exp=cafef00d/0", bus.rsp_rdata, bus.rsp_error); end
    @(negedge HCLK);
    checks++; if (bus.HWDATA !== 32'h1122_3344) begin failures++; $display("FAIL b2b_hwdata got=%h exp=11223344", bus.HWDATA); end
    @(negedge HCLK);
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL b2b_wr_rsp got=%b/%h exp=1/0", bus.rsp_valid, bus.rsp_rdata); end
    @(negedge HCLK);
  endtask

  task automatic test_reset_mid;
    bus.HREADY = 1'b1; bus.HRESP = 1'b0;
    drive_cmd(1'b0, 32'h0000_0700, 32'hFFFF_FFFF, 3'd2);
    @(negedge HCLK);
    bus.cmd_valid = 1'b0;
    @(negedge HCLK);
    bus.HREADY = 1'b0;
    checks++; if (bus.HWDATA !== 32'hFFFF_FFFF || bus.HADDR !== 32'h700) begin failures++; $display("FAIL rm_pre got=%h/%h exp=ffffffff/700", bus.HWDATA, bus.HADDR); end
    HRESETn = 1'b0;
    #1;
    checks++; if (bus.HADDR !== 32'h0 || bus.HWDATA !== 32'h0 || bus.HTRANS !== 2'b00 || bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rm_async got=%h/%h/%h/%b exp=0/0/0/1", bus.HADDR, bus.HWDATA, bus.HTRANS, bus.cmd_ready); end
    @(negedge HCLK);
    HRESETn = 1'b1;
    bus.HREADY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      checks++; if (bus.rsp_valid !== 1'b0 || bus.HTRANS !== 2'b00) begin failures++; $display("FAIL rm_no_rsp%0d got=%b/%h exp=0/0", i, bus.rsp_valid, bus.HTRANS); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    HRESETn = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 32'h0;
    bus.cmd_wdata = 32'h0;
    bus.cmd_size  = 3'd0;
    bus.HRDATA    = 32'h0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 1'b0;
    test_reset;
    test_word_read;
    test_byte_write_wait;
    test_narrow_read;
    test_misaligned;
    test_error_resp;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_master_ctrl.md
AHB_MASTER_CTRL -- requirements
Module: ahb_master_ctrl

Interface
REQ-001 SHALL have ports: HCLK  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: HRESETn  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: cmd_valid  in  1; cmd_ready  out  1; cmd_write  in  1; cmd_addr  in  32; cmd_wdata  in  32; cmd_size  in  3 (0 byte, 1 half, 2 word).
REQ-004 SHALL have ports: rsp_valid  out  1; rsp_error  out  1; rsp_rdata  out  32.
REQ-005 SHALL have ports: HADDR  out  32; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3; HPROT  out  4; HWDATA  out  32.
REQ-006 SHALL have ports: HRDATA  in  32; HREADY  in  1; HRESP  in  1, all three taken from the slave-response multiplexer output.
REQ-007 SHALL use parameter HPROT_VAL, default 4'b0011, data non-cacheable privileged access code driven on HPROT.

Function
REQ-008 SHALL implement FSM states IDLE, ADDR, DATA; cmd_ready = 1 only in IDLE.
REQ-009 SHALL accept a command on the edge where cmd_valid && cmd_ready, registering write, addr, wdata, size.
REQ-010 SHALL reject misaligned commands (size 1 with addr[0]=1; size 2 with addr[1:0]!=0; size >2): no bus transfer, stay IDLE, rsp_valid=1 and rsp_error=1 the next cycle.
REQ-011 SHALL move IDLE->ADDR on accepted aligned command; in ADDR drive HTRANS=NONSEQ (2'b10), HADDR, HWRITE, HSIZE from registered command.
REQ-012 SHALL remain in ADDR while HREADY=0; ADDR->DATA on edge with HREADY=1.
REQ-013 SHALL drive HTRANS=IDLE (2'b00) in IDLE and DATA; only single non-pipelined transfers, HBURST=3'b000 always.
REQ-014 SHALL drive HWDATA in DATA with lane replication: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-015 SHALL stay in DATA while HREADY=0, including the first HRESP=1 cycle of a two-cycle ERROR response.
REQ-016 SHALL on DATA edge with HREADY=1, HRESP=0 go IDLE and next cycle assert rsp_valid=1, rsp_error=0 for exactly one cycle.
REQ-017 SHALL on DATA edge with HREADY=1, HRESP=1 go IDLE and next cycle assert rsp_valid=1, rsp_error=1 for one cycle; rsp_rdata = 0.
REQ-018 SHALL for reads set rsp_rdata zero-extended: byte HRDATA lane addr[1:0]*8, half lane addr[1]*16, word full; writes give rsp_rdata = 0.
REQ-019 SHALL hold rsp_rdata/rsp_error stable until the next response; rsp_valid is a pulse, no back-pressure.
REQ-020 SHALL allow a new command in the same cycle rsp_valid is asserted (IDLE).

Reset
REQ-021 SHALL on HRESETn=0 immediately force IDLE, cmd_ready=1 once released, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, rsp_valid=0, rsp_error=0, rsp_rdata=0.
REQ-022 SHALL abandon any in-flight transfer on reset mid-operation with no response pulse afterwards.

Structure
REQ-023 SHALL place HTRANS encodings, HSIZE encodings, HBURST SINGLE and FSM state encoding in shared package ahb_pkg.
REQ-024 SHALL place write replication and read lane extraction in combinational sub-module ahb_lane_align.

Verification
REQ-025 Word read addr 0x100, HREADY=1, HRDATA=0xDEADBEEF -> NONSEQ one cycle, rsp_valid one cycle later, rsp_rdata=0xDEADBEEF, rsp_error=0.
REQ-026 Byte write addr 0x203 data 0x5A, 2 wait states -> HSIZE=0, HWDATA=0x5A5A5A5A held 3 DATA cycles, rsp_valid=1, rsp_error=0.
REQ-027 Half read addr 0x302, HRDATA=0x12345678 -> rsp_rdata=0x00001234.
REQ-028 Word write addr 0x401 -> HTRANS stays IDLE, rsp_valid=1 next cycle, rsp_error=1.
REQ-029 Read, DATA sees HRESP=1/HREADY=0 then HRESP=1/HREADY=1 -> HTRANS=IDLE throughout, rsp_error=1, rsp_rdata=0.
REQ-030 HRESETn low during DATA with HREADY=0 -> outputs at reset values immediately, no rsp_valid after release.
